// File: rtl/ins_queue_decode.sv
// rtl/ins_queue_decode.sv - FWFT instruction queue with MIPS field and target decode
// Holds fetched {instruction, pc} pairs and decodes the head entry combinationally.
module ins_queue_decode #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_ins,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [5:0]                 op,
  output logic [5:0]                 func,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 shamt,
  output logic [15:0]                imm16,
  output logic [25:0]                target,
  output logic [31:0]                imm_ext,
  output logic [ADDR_W-1:0]          pc_plus4,
  output logic [ADDR_W-1:0]          br_addr,
  output logic [ADDR_W-1:0]          j_addr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] LOW28 = ADDR_W'(28'hFFF_FFFF);

  logic [31:0]       ins_q [DEPTH];
  logic [ADDR_W-1:0] pc_q  [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ins_q[i] <= '0;
        pc_q[i]  <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push && !flush) begin
        ins_q[wr_ptr_q] <= in_ins;
        pc_q[wr_ptr_q]  <= in_pc;
      end
    end
  end

  // Head is forced to zero when empty so every decoded output reads 0.
  logic [31:0]       head_ins;
  logic [ADDR_W-1:0] head_pc, pc4, br_off;

  assign head_ins = out_valid ? ins_q[rd_ptr_q] : '0;
  assign head_pc  = out_valid ? pc_q[rd_ptr_q]  : '0;

  assign op     = head_ins[31:26];
  assign rs     = head_ins[25:21];
  assign rt     = head_ins[20:16];
  assign rd     = head_ins[15:11];
  assign shamt  = head_ins[10:6];
  assign func   = head_ins[5:0];
  assign imm16  = head_ins[15:0];
  assign target = head_ins[25:0];

  always_comb begin
    imm_ext = {{16{head_ins[15]}}, head_ins[15:0]};
    case (head_ins[31:26])
      6'h0C, 6'h0D, 6'h0E: imm_ext = {16'b0, head_ins[15:0]};
      6'h0F:               imm_ext = {head_ins[15:0], 16'b0};
      default:             ;
    endcase
  end

  assign pc4      = head_pc + ADDR_W'(4);
  assign br_off   = {{(ADDR_W-18){head_ins[15]}}, head_ins[15:0], 2'b00};
  assign pc_plus4 = out_valid ? pc4 : '0;
  assign br_addr  = out_valid ? (pc4 + br_off) : '0;
  assign j_addr   = out_valid ? ((pc4 & ~LOW28) | ADDR_W'({head_ins[25:0], 2'b00})) : '0;

endmodule

// File: tb/tb_ins_queue_decode.sv
// tb/tb_ins_queue_decode.sv - self-checking bench for ins_queue_decode
module tb_ins_queue_decode;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] in_ins, in_pc;
  logic        in_ready, out_valid;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] target;
  logic [31:0] imm_ext, pc_plus4, br_addr, j_addr;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;
  logic [31:0] mq_ins[$];
  logic [31:0] mq_pc[$];

  ins_queue_decode #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ins(in_ins), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .imm16(imm16), .target(target), .imm_ext(imm_ext),
    .pc_plus4(pc_plus4), .br_addr(br_addr), .j_addr(j_addr), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decode of the model's head entry straight from the ISA field rules.
  task automatic check_all();
    logic [31:0] ins, pc, pc4, ext, br, j;
    logic [5:0]  eop;
    ins = 0; pc = 0; pc4 = 0; ext = 0; br = 0; j = 0;
    if (mq_ins.size() > 0) begin
      ins = mq_ins[0];
      pc  = mq_pc[0];
      pc4 = pc + 32'd4;
      eop = 6'(ins >> 26);
      if (eop >= 6'h0C && eop <= 6'h0E) ext = ins & 32'hFFFF;
      else if (eop == 6'h0F)            ext = (ins & 32'hFFFF) << 16;
      else                              ext = 32'($signed(16'(ins)));
      br  = pc4 + 32'($signed(16'(ins))) * 32'd4;
      j   = (pc4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    end
    chk("count", 64'(count), 64'(mq_ins.size()));
    chk("in_ready", 64'(in_ready), 64'(mq_ins.size() < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(mq_ins.size() > 0));
    chk("fields", {op, rs, rt, rd, shamt, func},
        64'({ins[31:26], ins[25:21], ins[20:16], ins[15:11], ins[10:6], ins[5:0]}));
    chk("imm16_target", {imm16, target}, 64'({ins[15:0], ins[25:0]}));
    chk("imm_ext", 64'(imm_ext), 64'(ext));
    chk("pc_plus4", 64'(pc_plus4), 64'(pc4));
    chk("br_addr", 64'(br_addr), 64'(br));
    chk("j_addr", 64'(j_addr), 64'(j));
  endtask

  task automatic step();
    bit do_push, do_pop;
    check_all();
    @(posedge clk);
    do_pop  = out_ready && (mq_ins.size() > 0);
    do_push = in_valid && (mq_ins.size() < DEPTH);
    if (flush) begin
      mq_ins.delete();
      mq_pc.delete();
    end else begin
      if (do_pop) begin
        void'(mq_ins.pop_front());
        void'(mq_pc.pop_front());
      end
      if (do_push) begin
        mq_ins.push_back(in_ins);
        mq_pc.push_back(in_pc);
      end
    end
    #1;
  endtask

  task automatic push_one(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1; in_ins = ins; in_pc = pc; out_ready = 0;
    step();
    in_valid = 0;
  endtask

  task automatic pop_one();
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  typedef struct {
    logic [31:0] ins, pc;
    logic [5:0]  e_op;
    logic [31:0] e_ext, e_pc4, e_br, e_j;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h3C01_1234, 32'h0040_0000, 6'h0F, 32'h1234_0000, 32'h0040_0004, 32'h0040_48D4, 32'h0004_48D0};
    vecs[1] = '{32'h1022_FFFF, 32'h0040_0010, 6'h04, 32'hFFFF_FFFF, 32'h0040_0014, 32'h0040_0010, 32'h008B_FFFC};
    vecs[2] = '{32'h3422_8000, 32'h0040_0014, 6'h0D, 32'h0000_8000, 32'h0040_0018, 32'h003E_0018, 32'h008A_0000};
    vecs[3] = '{32'h0810_0004, 32'h0040_0020, 6'h02, 32'h0000_0004, 32'h0040_0024, 32'h0040_0034, 32'h0040_0010};
    vecs[4] = '{32'h1000_7FFF, 32'hFFFF_FFFC, 6'h04, 32'h0000_7FFF, 32'h0000_0000, 32'h0001_FFFC, 32'h0001_FFFC};
    vecs[5] = '{32'h3000_FFFF, 32'h0000_0000, 6'h0C, 32'h0000_FFFF, 32'h0000_0004, 32'h0000_0000, 32'h0003_FFFC};

    rst_n = 0; in_valid = 0; flush = 0; out_ready = 0; in_ins = 0; in_pc = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check_all();

    push_one(32'h3C01_1234, 32'h0040_0000);
    chk("lui_out_valid", 64'(out_valid), 64'd1);
    chk("lui_op", 64'(op), 64'h0F);
    chk("lui_rt", 64'(rt), 64'd1);
    chk("lui_imm_ext", 64'(imm_ext), 64'h1234_0000);
    chk("lui_pc_plus4", 64'(pc_plus4), 64'h0040_0004);
    chk("lui_count", 64'(count), 64'd1);
    pop_one();

    for (int i = 0; i < 6; i++) begin
      push_one(vecs[i].ins, vecs[i].pc);
      chk($sformatf("vec%0d_op", i), 64'(op), 64'(vecs[i].e_op));
      chk($sformatf("vec%0d_imm_ext", i), 64'(imm_ext), 64'(vecs[i].e_ext));
      chk($sformatf("vec%0d_pc_plus4", i), 64'(pc_plus4), 64'(vecs[i].e_pc4));
      chk($sformatf("vec%0d_br_addr", i), 64'(br_addr), 64'(vecs[i].e_br));
      chk($sformatf("vec%0d_j_addr", i), 64'(j_addr), 64'(vecs[i].e_j));
      pop_one();
    end

    // Fill past capacity with the consumer stalled.
    in_valid = 1; out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      in_ins = 32'hA000_0000 + 32'(i); in_pc = 32'h100 + 32'(i * 4);
      step();
    end
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head", 64'(imm16), 64'h0000);

    // Pop against a full queue: the offered word must be refused.
    out_ready = 1; in_ins = 32'hB000_0000; in_pc = 32'h200;
    step();
    chk("full_pop_count", 64'(count), 64'd3);
    chk("full_pop_head", 64'(imm16), 64'h0001);
    for (int i = 1; i < 8; i++) begin
      in_ins = 32'hB000_0000 + 32'(i); in_pc = 32'h200 + 32'(i * 4);
      step();
    end
    chk("wrap_head", 64'(imm16), 64'h0005);
    chk("wrap_count", 64'(count), 64'd3);

    flush = 1; in_valid = 1; out_ready = 1; in_ins = 32'hC000_0001;
    step();
    flush = 0; in_valid = 0; out_ready = 0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_outputs", 64'(imm_ext | pc_plus4 | br_addr | j_addr), 64'd0);
    check_all();

    push_one(32'h2001_0005, 32'h300);
    push_one(32'h2002_0006, 32'h304);
    chk("pre_reset_count", 64'(count), 64'd2);
    #2 rst_n = 0;
    #1;
    mq_ins.delete(); mq_pc.delete();
    chk("async_count", 64'(count), 64'd0);
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_pc_plus4", 64'(pc_plus4), 64'd0);
    check_all();
    #1 rst_n = 1;
    @(posedge clk); #1;
    push_one(32'h2003_0007, 32'h308);
    chk("post_reset_valid", 64'(out_valid), 64'd1);
    chk("post_reset_imm", 64'(imm16), 64'h0007);
    pop_one();

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_ins    = $urandom;
      if ($urandom_range(0, 1) == 1) in_ins[31:26] = 6'($urandom_range(12, 15));
      in_pc     = $urandom;
      step();
    end
    flush = 0; in_valid = 0; out_ready = 0;
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
